serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer built around one shared `fa` full-adder cell.
- Accepts two W-bit operands with a start/ready handshake and feeds them LSB-first through the single `fa` instance, one bit per clock.
- Collects the sum bits in a shift register and reports the result with a one-cycle done pulse.
- Serves as the multi-bit arithmetic unit in designs where gate count matters more than latency.

Parameters:
W, 8, operand and result width in bits (W >= 2)
CW, $clog2(W+1), bit-counter width (derived; do not override)

Ports:
clk      input   1   rising-edge clock
rst_n    input   1   synchronous active-low reset
start    input   1   request a new operation; sampled only when ready=1
a        input   W   operand A, captured on the accepted start edge
b        input   W   operand B, captured on the accepted start edge
ready    output  1   high only in IDLE; controller can accept start
busy     output  1   high in RUN
done     output  1   one-cycle pulse; sum/cout valid
sum      output  W   result, held until the next accepted start
cout     output  1   final carry-out, held with sum

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0.
  - Internal operand shift registers, carry flop and counter are cleared.
  - Reset has priority over every other event and aborts an operation in progress; no done pulse follows.
- States:
  - IDLE: ready=1. On start=1, capture a, b, carry=0, cnt=0, and go to RUN.
  - RUN: busy=1. Each edge:
    - The `fa` cell computes {c_out, s} = a_sh[0] + b_sh[0] + carry.
    - a_sh and b_sh shift right by 1.
    - s shifts into sum_sh at the MSB end.
    - carry <= c_out; cnt <= cnt+1.
    - On the edge where cnt==W-1, load sum <= final sum_sh, cout <= c_out, and go to DONE.
  - DONE: done=1 for exactly one cycle; unconditional transition to IDLE on the next edge.
- Timing:
  - Start accepted at edge E0.
  - W RUN edges E1..EW.
  - done high during the cycle after EW; sum/cout visible in that cycle.
  - ready returns at E(W+1).
  - Latency: W+1 edges from accept to done.
  - Throughput: one operation per W+2 cycles with start held high.
- Handshake rules:
  - start is ignored while busy or done is high; operands applied at that time are not captured.
  - a and b may change freely after the accept edge.
- Output hold: sum and cout change only at the DONE-entry edge or at reset. Intermediate bits never appear on sum.
- Arithmetic: result is (a+b) mod 2^W, with cout = bit W of the true sum.
- Datapath structure: exactly one `fa` instance; no `+` operator on operand data. The counter may use `+`.
- Wrap-around: the counter is bounded by the W-1 compare and never wraps.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start edge.
  - When sub=1: b bits are inverted before entering `fa`, and the carry flop is initialised to 1.
  - Result: sum=(a-b) mod 2^W; cout=1 means no borrow (a>=b unsigned).
  - When sub=0: behaviour is identical to the base block.
- Undefined:
  - No sub port.
  - Initial carry is always 0; add only.

Test Plan:
- Reset, then W=8, a=0x5A, b=0x3C, start one cycle -> done pulses exactly 9 edges after accept; sum=0x96, cout=0; ready=0 during those 9 cycles, then 1.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0x80, b=0x80 -> sum=0x00, cout=1; then a=0x00, b=0x00 -> sum=0x00, cout=0.
- Accept a=0x11, b=0x22; mid-RUN assert start with a=0xFF, b=0xFF -> ignored; sum=0x33, cout=0; only one done pulse.
- start held high continuously with a=0x01, b=0x01 -> done every 10 cycles; sum=0x02 each time; sum stable between pulses.
- Reset asserted (rst_n=0) at the 4th RUN edge of a=0xAA, b=0x55 -> next cycle state IDLE, sum=0, cout=0, done never pulses; a following op 0x0F+0x01 gives 0x10, cout=0.
- With SERIAL_ADD_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; sub=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl -- bit-serial adder sequencer around a single full-adder.
//
// Two W-bit operands are captured on an accepted start, then fed LSB-first
// through one shared `fa` cell, one bit per clock. Sum bits collect in a
// shift register. The finished result is copied to `sum`/`cout` on the edge
// that enters DONE, and `done` pulses for one cycle.
//
// Optional feature (macro SERIAL_ADD_SUB_EN):
//   Adds input `sub`. When it is captured high, the b bits are inverted on
//   their way into the adder and the carry starts at 1, which gives a - b.
//   In that mode cout=1 means no borrow. With the macro undefined the block
//   only adds, and the initial carry is always 0.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request an operation; sampled only while ready=1
//   a, b   in   W-bit operands, captured on the accepted start edge
//   sub    in   (SERIAL_ADD_SUB_EN only) subtract select, captured with a/b
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle pulse; sum/cout valid
//   sum    out  W-bit result, held until the next DONE entry or reset
//   cout   out  final carry-out, held with sum
// ---------------------------------------------------------------------------

module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);
    // Derived counter width; not meant to be overridden.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   a_sh_reg;
    logic [W-1:0]   b_sh_reg;
    logic [W-1:0]   sum_sh_reg;
    logic [W-1:0]   sum_reg;
    logic [CW-1:0]  cnt_reg;
    logic           carry_reg;
    logic           cout_reg;
    logic           ready_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           sub_reg;

    logic           fa_y;
    logic           fa_s;
    logic           fa_co;
    logic [W-1:0]   sum_sh_next;
    logic           last_bit;

`ifndef SERIAL_ADD_SUB_EN
    // Add-only build: the inversion term is tied off and optimises away.
    assign sub_reg = 1'b0;
`endif

    // Subtraction is a + ~b + 1. The +1 comes from the carry flop being
    // preset when the operation is accepted.
    assign fa_y = b_sh_reg[0] ^ sub_reg;

    fa u_fa (
        .x  (a_sh_reg[0]),
        .y  (fa_y),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB. After W shifts, bit 0 of the result
    // has reached position 0.
    assign sum_sh_next = {fa_s, sum_sh_reg[W-1:1]};
    assign last_bit    = (cnt_reg == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        sum_sh_reg <= '0;
                        cnt_reg    <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        sub_reg    <= sub;
                        carry_reg  <= sub;
`else
                        carry_reg  <= 1'b0;
`endif
                        state_reg  <= ST_RUN;
                        ready_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                    end
                end

                ST_RUN: begin
                    a_sh_reg   <= {1'b0, a_sh_reg[W-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[W-1:1]};
                    sum_sh_reg <= sum_sh_next;
                    carry_reg  <= fa_co;
                    // The W-1 compare ends the run, so the counter never wraps.
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        sum_reg   <= sum_sh_next;
                        cout_reg  <= fa_co;
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign cout  = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl -- self-checking bench for serial_add_ctrl (W=8).
// Runs a table of directed vectors, then random operands checked against
// plain-arithmetic results. After that come hand-written sequences: start
// asserted mid-run, start held high, and reset in the middle of a run.
// With SERIAL_ADD_SUB_EN defined, subtract vectors are added.
// ---------------------------------------------------------------------------

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec;
    int n_err;

    logic [W-1:0] last_sum;
    logic         last_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t tbl[$];

    serial_add_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the arithmetic meaning of the operation. This is not a bit
    // model. Bit W is cout and the low W bits are sum.
    function automatic logic [W:0] model(logic [W-1:0] x, logic [W-1:0] y, logic s);
        int r;
        logic [W:0] res;
        if (s) begin
            r   = int'(x) - int'(y);
            res = {(x >= y), r[W-1:0]};
        end else begin
            r   = int'(x) + int'(y);
            res = r[W:0];
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete operation. Accepts at E0 and expects done in the cycle
    // after the W-th RUN edge. While waiting it checks that ready, busy and
    // sum behave. If inj is set, a bogus start is pulsed mid-run.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, input logic [W-1:0] es,
                          input logic ec, input logic inj, input string name);
        int  k;
        bit  got;
        int  extra;
        @(negedge clk);
        chk({name, " ready_idle"}, 32'(ready), 32'd1);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        k     = 0;
        got   = 0;
        while (!got && k <= W + 3) begin
            if (done) begin
                got = 1;
            end else begin
                chk({name, " ready_run"}, 32'(ready), 32'd0);
                chk({name, " busy_run"},  32'(busy),  32'd1);
                chk({name, " sum_hold"},  32'(sum),   32'(last_sum));
                chk({name, " cout_hold"}, 32'(cout),  32'(last_cout));
                if (inj && k == 2) begin
                    start = 1'b1;
                    a     = '1;
                    b     = '1;
                end
                if (inj && k == 4) start = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk({name, " latency"},    32'(k),     32'(W));
        chk({name, " ready_done"}, 32'(ready), 32'd0);
        chk({name, " busy_done"},  32'(busy),  32'd0);
        chk({name, " sum"},        32'(sum),   32'(es));
        chk({name, " cout"},       32'(cout),  32'(ec));
        $display("op %s a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h cout=%0d (exp 0x%02h/%0d) lat=%0d",
                 name, ia, ib, isub, sum, cout, es, ec, k);
        last_sum  = es;
        last_cout = ec;
        @(negedge clk);
        chk({name, " done_pulse"}, 32'(done),  32'd0);
        chk({name, " ready_back"}, 32'(ready), 32'd1);
        if (inj) begin
            extra = 0;
            repeat (W + 4) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk({name, " single_done"}, 32'(extra), 32'd0);
            chk({name, " sum_after"},   32'(sum),   32'(es));
        end
    endtask

    // Absolute bound on the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        logic         rs;
        int           n_done;
        int           last_k;
        int           j;

        n_vec     = 0;
        n_err     = 0;
        last_sum  = '0;
        last_cout = 1'b0;

        tbl.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        tbl.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
        tbl.push_back('{8'h42, 8'h42, 1'b1, 8'h00, 1'b1});
        tbl.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
`endif

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst busy",  32'(busy),  32'd0);
        chk("rst done",  32'(done),  32'd0);
        chk("rst sum",   32'(sum),   32'd0);
        chk("rst cout",  32'(cout),  32'd0);
        rst_n = 1'b1;

        foreach (tbl[i])
            run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].es, tbl[i].ec, 1'b0, "tbl");

        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rs);
            run_op(ra, rb, rs, r[W-1:0], r[W], 1'b0, "rand");
        end

        // A start pulse with 0xFF operands arrives mid-run and must be ignored.
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b1, "inject");

        // start held high: one result every W+2 cycles.
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        n_done = 0;
        last_k = -1;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (done) begin
                chk("held sum", 32'(sum), 32'h02);
                if (last_k >= 0)
                    chk("held period", 32'(k - last_k), 32'(W + 2));
                else
                    chk("held first", 32'(k), 32'(W));
                last_k = k;
                n_done++;
            end else if (last_k >= 0) begin
                chk("held sum_stable", 32'(sum), 32'h02);
            end else begin
                chk("held sum_prev", 32'(sum), 32'(last_sum));
            end
        end
        chk("held count", 32'(n_done), 32'd3);
        $display("op held a=0x01 b=0x01 pulses=%0d sum=0x%02h", n_done, sum);
        start = 1'b0;
        j = 0;
        while (!ready && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("held drain", 32'(ready), 32'd1);
        last_sum  = 8'h02;
        last_cout = 1'b0;

        // Reset at the 4th RUN edge of 0xAA+0x55 aborts the operation.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort busy",  32'(busy),  32'd0);
        chk("abort done",  32'(done),  32'd0);
        chk("abort sum",   32'(sum),   32'd0);
        chk("abort cout",  32'(cout),  32'd0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort no_done", 32'(n_done), 32'd0);
        $display("op abort a=0xAA b=0x55 -> sum=0x%02h cout=%0d", sum, cout);
        last_sum  = '0;
        last_cout = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
